// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the multi-channel clock divider.
//   CNT_W_DEF  default counter/divisor width
//   MIN_DIV    smallest divisor a channel will run with
//   clamp_div  raises any divisor below MIN_DIV to MIN_DIV
package clkdiv_pkg;

   localparam int CNT_W_DEF = 20;
   localparam int MIN_DIV   = 2;

   function automatic logic [31:0] clamp_div(input logic [31:0] value);
      return (value < 32'(MIN_DIV)) ? 32'(MIN_DIV) : value;
   endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel.
// A counter runs 0..D-1 while en_i is high. The square wave is registered from
// the next count, so it always equals (cnt >= D/2). A written divisor is parked
// in div_nxt and only installed on the wrap cycle (or a sync restart), so a
// period is never cut short or stretched.
// Ports:
//   clk100, rst    clock, asynchronous active-high reset
//   en_i           count enable
//   sync_i         restart request (tie low when phase alignment is not built)
//   wr_i, wr_val_i divisor write strobe for this channel and its value
//   pend_o         a written divisor is waiting for the period boundary
//   ack_o          one-cycle pulse when the waiting divisor is installed
//   tick_o         one-cycle pulse on the last cycle of each period
//   clk_out_o      divided square wave, flop-driven
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(4)
) (
   input  logic             clk100,
   input  logic             rst,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_val_i,
   output logic             pend_o,
   output logic             ack_o,
   output logic             tick_o,
   output logic             clk_out_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_cur_q, div_cur_d;
   logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
   logic             pend_q, pend_d;
   logic             ack_q, ack_d;
   logic             clk_out_q, clk_out_d;
   logic             last, restart, install;

   assign last    = (cnt_q == div_cur_q - CNT_W'(1));
   // sync outranks a normal wrap; both restart the period at count 0
   assign restart = en_i & (last | sync_i);
   assign install = restart & pend_q;

   always_comb begin
      cnt_d     = cnt_q;
      div_cur_d = div_cur_q;
      div_nxt_d = div_nxt_q;
      pend_d    = pend_q;
      ack_d     = install;
      if (en_i) begin
         if (restart) begin
            cnt_d = '0;
            if (pend_q) div_cur_d = div_nxt_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      // a write landing on the install cycle survives: the install consumed
      // the old div_nxt, the new value stays pending
      if (wr_i) begin
         div_nxt_d = CNT_W'(clamp_div(32'(wr_val_i)));
         pend_d    = 1'b1;
      end else if (install) begin
         pend_d = 1'b0;
      end
      clk_out_d = (cnt_d >= (div_cur_d >> 1));
   end

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         div_cur_q <= DIV_RST;
         div_nxt_q <= '0;
         pend_q    <= 1'b0;
         ack_q     <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_cur_q <= div_cur_d;
         div_nxt_q <= div_nxt_d;
         pend_q    <= pend_d;
         ack_q     <= ack_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign pend_o    = pend_q;
   assign ack_o     = ack_q;
   assign tick_o    = en_i & last & ~sync_i;
   assign clk_out_o = clk_out_q;

   // a reset divisor below MIN_DIV is a configuration error
   a_div_min: assert property (@(posedge clk100) disable iff (rst)
                               div_cur_q >= CNT_W'(MIN_DIV))
      else $error("clkdiv_chan: divisor below minimum");

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH independent run-time programmable clock dividers.
// Each channel gives a flop-driven ~50% square wave and a one-cycle tick on the
// last cycle of its period. Divisor writes are applied at the period boundary.
// Optional build macro CLKDIV_SYNC_EN adds a 'sync' input that restarts all
// channels together so they become phase-aligned.
// Ports:
//   clk100, rst  clock, asynchronous active-high reset
//   en           global count enable
//   sync         (CLKDIV_SYNC_EN only) restart all channels at count 0
//   div_wr       divisor write strobe
//   div_ch       target channel; values >= NUM_CH are ignored
//   div_val      new divisor (values below 2 are stored as 2)
//   div_pend     per channel: divisor waiting for the boundary
//   div_ack      per channel: one-cycle install pulse
//   tick         per channel: last cycle of period
//   clk_out      per channel: divided square wave
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter int                      NUM_CH   = 2,
   parameter int                      CNT_W    = CNT_W_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {20'd100000, 20'd4},
   parameter int                      CH_W     = 1
) (
   input  logic              clk100,
   input  logic              rst,
   input  logic              en,
`ifdef CLKDIV_SYNC_EN
   input  logic              sync,
`endif
   input  logic              div_wr,
   input  logic [CH_W-1:0]   div_ch,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] div_pend,
   output logic [NUM_CH-1:0] div_ack,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out
);

   logic sync_w;

`ifdef CLKDIV_SYNC_EN
   assign sync_w = sync & en;
`else
   assign sync_w = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_ch;
      // out-of-range channel numbers match no instance, so the write is dropped
      assign wr_ch = div_wr & (int'(div_ch) == i);

      clkdiv_chan #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
      ) u_chan (
         .clk100    (clk100),
         .rst       (rst),
         .en_i      (en),
         .sync_i    (sync_w),
         .wr_i      (wr_ch),
         .wr_val_i  (div_val),
         .pend_o    (div_pend[i]),
         .ack_o     (div_ack[i]),
         .tick_o    (tick[i]),
         .clk_out_o (clk_out[i])
      );
   end

endmodule
